prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream boot stage for the 5-bit CPU.
- Receives a framed byte stream from a host and writes it as 11-bit instruction/data words into CPU program RAM through the CPU's RAM write port.
- Asserts PC_Enable to release the CPU only after the frame's checksum verifies.
- Replaces manual driving of RAM_Write_Address, RAM_Write_Data and RAM_Write_Enable.

Parameters:
- DATA_W, 11, RAM word width; high data byte carries bits DATA_W-1:8.
- ADDR_W, 3, RAM address width; RAM depth is 2^ADDR_W = 8.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 255, max clk cycles between accepted bytes inside a frame.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle; may be high every cycle.
- rx_data  in  8  received byte.
- RAM_Write_Data  out  DATA_W  word to CPU RAM.
- RAM_Write_Address  out  ADDR_W  target RAM address.
- RAM_Write_Enable  out  1  one-cycle write pulse.
- PC_Enable  out  1  CPU run enable.
- busy  out  1  frame in progress.
- done  out  1  load verified; CPU running.
- error  out  1  frame rejected.

Behaviour:
- Frame format: SYNC, BASE, COUNT, then COUNT pairs of (HI, LO), then CSUM.
- Word value is {HI[2:0], LO}.
- CSUM must equal the mod-256 sum of BASE, COUNT and all HI/LO bytes.
- States: IDLE, ADDR, COUNT, DATA_HI, DATA_LO, CHECK, RUN, ERROR. All outputs are registered.
- Reset:
  - State goes to IDLE.
  - All outputs go to 0, including RAM_Write_Data and RAM_Write_Address.
  - Checksum, counters and timer are cleared.
  - A reset mid-frame aborts the frame. No further writes occur, and words already written stay in RAM.
- IDLE: a byte equal to SYNC_BYTE moves to ADDR and clears the checksum. Any other byte is ignored.
- ADDR:
  - rx_data[7:ADDR_W] nonzero moves to ERROR.
  - Otherwise the base address is latched, the byte is added to the checksum, and state moves to COUNT.
- COUNT:
  - N = rx_data must lie in 1..2^ADDR_W; otherwise move to ERROR.
  - On a valid N, remaining = N, the byte is added to the checksum, and state moves to DATA_HI.
- DATA_HI:
  - rx_data[7:DATA_W-8] nonzero moves to ERROR.
  - Otherwise HI is latched, the byte is added to the checksum, and state moves to DATA_LO.
- DATA_LO: on the accepting edge:
  - RAM_Write_Data = {HI, LO}.
  - RAM_Write_Address = the current address.
  - RAM_Write_Enable = 1 for exactly the following cycle (write latency 1 cycle after LO is accepted).
  - The address then increments modulo 2^ADDR_W, so 7 wraps to 0.
  - remaining decrements. If remaining reaches 0, go to CHECK; otherwise go to DATA_HI.
- Between writes, RAM_Write_Data and RAM_Write_Address hold their last values.
- CHECK:
  - CSUM match moves to RUN. Mismatch moves to ERROR.
  - Words are already written either way; no rollback.
- RUN:
  - PC_Enable = 1 and done = 1.
  - rx is ignored, and the state is held until reset.
- ERROR:
  - error = 1 and PC_Enable = 0.
  - A SYNC_BYTE moves to ADDR, clearing error and the checksum. Other bytes are ignored.
- busy = 1 in ADDR, COUNT, DATA_HI, DATA_LO and CHECK.
- Timeout:
  - In busy states, an idle-cycle counter resets on each rx_valid and increments otherwise.
  - When the counter reaches TIMEOUT, move to ERROR.
  - If rx_valid arrives in the same cycle as the timeout, rx_valid wins.
- Back-to-back bytes: rx_valid high every cycle must be accepted without loss. This gives one write per 2 bytes.
- A SYNC_BYTE value inside a frame is treated as data; there is no resynchronisation mid-frame.

Test Plan:
- Basic load: after reset, send A5,00,02,05,90,06,5C,F9 -> RAM[0]=0x590, then RAM[1]=0x65C; each RAM_Write_Enable is a single-cycle pulse one cycle after its LO byte; then done=1, PC_Enable=1, error=0.
- Wrap: send A5,07,02,00,03,05,90,A1 -> writes RAM[7]=0x003, then RAM[0]=0x590; PC_Enable=1.
- Bad checksum, then recovery:
  - Send the basic frame with CSUM=00 -> two writes occur, error=1, PC_Enable=0.
  - Resend the correct frame -> error=0, done=1.
- Illegal fields -> ERROR with no write pulses:
  - A5,00,00 (count 0).
  - A5,00,09 (count 9).
  - A5,00,01,08 (HI byte 0x08).
  - A5,08 (base address 8).
- Timeout: with TIMEOUT=16, send A5,00,02 then idle -> error=1 exactly 16 cycles after the last rx_valid, busy=0. Repeat with a byte on cycle 16 -> no error.
- Reset mid-frame: reset asserted after A5,00,02,05 -> all outputs 0 on the next edge; subsequent bytes 90,06 are ignored with no write pulses; a full frame after that loads normally.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: boot-stage frame receiver. It parses SYNC/BASE/COUNT/(HI,LO)*/CSUM
// frames from a byte stream, writes each word into CPU program RAM and releases the
// CPU (PC_Enable) only once the frame checksum verifies.
module prog_loader #(
    parameter int unsigned DATA_W    = 11,
    parameter int unsigned ADDR_W    = 3,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic [DATA_W-1:0] RAM_Write_Data,
    output logic [ADDR_W-1:0] RAM_Write_Address,
    output logic              RAM_Write_Enable,
    output logic              PC_Enable,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned HI_W  = DATA_W - 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StAddr   = 3'd1;
    localparam logic [2:0] StCount  = 3'd2;
    localparam logic [2:0] StDataHi = 3'd3;
    localparam logic [2:0] StDataLo = 3'd4;
    localparam logic [2:0] StCheck  = 3'd5;
    localparam logic [2:0] StRun    = 3'd6;
    localparam logic [2:0] StError  = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [HI_W-1:0]   hi_q, hi_d;
    logic [7:0]        csum_q, csum_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic [DATA_W-1:0] wdata_d;
    logic [ADDR_W-1:0] waddr_d;
    logic              we_d;
    logic              in_frame;
    logic              busy_d;
    logic              is_sync;
    logic              count_ok;

    assign is_sync  = (rx_data == SYNC_BYTE);
    assign count_ok = (rx_data != 8'd0) && ({24'd0, rx_data} <= DEPTH);
    assign in_frame = (state_q == StAddr) || (state_q == StCount) || (state_q == StDataHi) ||
                      (state_q == StDataLo) || (state_q == StCheck);
    assign busy_d   = (state_d == StAddr) || (state_d == StCount) || (state_d == StDataHi) ||
                      (state_d == StDataLo) || (state_d == StCheck);

    // Next-state logic: frame parsing, checksum accumulation, write generation, timeout
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        hi_d        = hi_q;
        csum_d      = csum_q;
        idle_d      = '0;
        wdata_d     = RAM_Write_Data;
        waddr_d     = RAM_Write_Address;
        we_d        = 1'b0;

        case (state_q)
            StIdle, StError: begin
                if (rx_valid && is_sync) begin
                    state_d = StAddr;
                    csum_d  = 8'd0;
                end
            end
            StAddr: begin
                if (rx_valid) begin
                    if (rx_data[7:ADDR_W] != '0) begin
                        state_d = StError;
                    end else begin
                        addr_d  = rx_data[ADDR_W-1:0];
                        csum_d  = csum_q + rx_data;
                        state_d = StCount;
                    end
                end
            end
            StCount: begin
                if (rx_valid) begin
                    if (!count_ok) begin
                        state_d = StError;
                    end else begin
                        remaining_d = rx_data[ADDR_W:0];
                        csum_d      = csum_q + rx_data;
                        state_d     = StDataHi;
                    end
                end
            end
            StDataHi: begin
                if (rx_valid) begin
                    if (rx_data[7:HI_W] != '0) begin
                        state_d = StError;
                    end else begin
                        hi_d    = rx_data[HI_W-1:0];
                        csum_d  = csum_q + rx_data;
                        state_d = StDataLo;
                    end
                end
            end
            StDataLo: begin
                if (rx_valid) begin
                    wdata_d     = {hi_q, rx_data};
                    waddr_d     = addr_q;
                    we_d        = 1'b1;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W + 1)'(1);
                    csum_d      = csum_q + rx_data;
                    state_d     = (remaining_q == (ADDR_W + 1)'(1)) ? StCheck : StDataHi;
                end
            end
            StCheck: begin
                // Words are already in RAM; a mismatch only withholds the CPU release
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? StRun : StError;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Idle-cycle watchdog inside a frame; a byte on the expiry cycle still wins
        if (in_frame && !rx_valid) begin
            if (idle_q == TW'(TIMEOUT - 1)) begin
                state_d = StError;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
    end

    // State and registered outputs; outputs are decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StIdle;
            addr_q            <= '0;
            remaining_q       <= '0;
            hi_q              <= '0;
            csum_q            <= 8'd0;
            idle_q            <= '0;
            RAM_Write_Data    <= '0;
            RAM_Write_Address <= '0;
            RAM_Write_Enable  <= 1'b0;
            PC_Enable         <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            remaining_q       <= remaining_d;
            hi_q              <= hi_d;
            csum_q            <= csum_d;
            idle_q            <= idle_d;
            RAM_Write_Data    <= wdata_d;
            RAM_Write_Address <= waddr_d;
            RAM_Write_Enable  <= we_d;
            PC_Enable         <= (state_d == StRun);
            busy              <= busy_d;
            done              <= (state_d == StRun);
            error             <= (state_d == StError);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed-vector bench for prog_loader (TIMEOUT shortened to 16).
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [10:0] RAM_Write_Data;
    logic [2:0]  RAM_Write_Address;
    logic        RAM_Write_Enable;
    logic        PC_Enable;
    logic        busy;
    logic        done;
    logic        error;

    int n_vec = 0;
    int n_bad = 0;
    int wr_count = 0;
    int dbl_count = 0;
    logic we_prev = 1'b0;
    logic [10:0] mem [8];

    prog_loader #(
        .DATA_W   (11),
        .ADDR_W   (3),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT  (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .RAM_Write_Data   (RAM_Write_Data),
        .RAM_Write_Address(RAM_Write_Address),
        .RAM_Write_Enable (RAM_Write_Enable),
        .PC_Enable        (PC_Enable),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    // RAM model fed by the write port; also counts back-to-back enable cycles
    always @(negedge clk) begin
        if (RAM_Write_Enable === 1'b1) begin
            wr_count = wr_count + 1;
            mem[RAM_Write_Address] = RAM_Write_Data;
            if (we_prev === 1'b1) dbl_count = dbl_count + 1;
        end
        we_prev = RAM_Write_Enable;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 11'h000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (RAM_Write_Data !== 11'h000) begin n_bad++; $display("FAIL rst_data: got %h want 000", RAM_Write_Data); end
        n_vec++; if (RAM_Write_Address !== 3'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", RAM_Write_Address); end
        n_vec++; if (RAM_Write_Enable !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", RAM_Write_Enable); end
        n_vec++; if (PC_Enable !== 1'b0) begin n_bad++; $display("FAIL rst_pc: got %b want 0", PC_Enable); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_vec++; if (error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", error); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int w0;
        do_reset();
        w0 = wr_count;
        send(8'hA5); send(8'h00); send(8'h02); send(8'h05);
        n_vec++; if (RAM_Write_Enable !== 1'b0) begin n_bad++; $display("FAIL basic_we_early: got %b want 0", RAM_Write_Enable); end
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        send(8'h90);
        n_vec++; if (RAM_Write_Enable !== 1'b1) begin n_bad++; $display("FAIL basic_we0: got %b want 1", RAM_Write_Enable); end
        n_vec++; if (RAM_Write_Data !== 11'h590) begin n_bad++; $display("FAIL basic_data0: got %h want 590", RAM_Write_Data); end
        n_vec++; if (RAM_Write_Address !== 3'd0) begin n_bad++; $display("FAIL basic_addr0: got %0d want 0", RAM_Write_Address); end
        send(8'h06);
        n_vec++; if (RAM_Write_Enable !== 1'b0) begin n_bad++; $display("FAIL basic_we_drop: got %b want 0", RAM_Write_Enable); end
        n_vec++; if (RAM_Write_Data !== 11'h590) begin n_bad++; $display("FAIL basic_data_hold: got %h want 590", RAM_Write_Data); end
        send(8'h5C);
        n_vec++; if (RAM_Write_Enable !== 1'b1) begin n_bad++; $display("FAIL basic_we1: got %b want 1", RAM_Write_Enable); end
        n_vec++; if (RAM_Write_Data !== 11'h65C) begin n_bad++; $display("FAIL basic_data1: got %h want 65C", RAM_Write_Data); end
        n_vec++; if (RAM_Write_Address !== 3'd1) begin n_bad++; $display("FAIL basic_addr1: got %0d want 1", RAM_Write_Address); end
        n_vec++; if (PC_Enable !== 1'b0) begin n_bad++; $display("FAIL basic_pc_early: got %b want 0", PC_Enable); end
        send(8'hF9);
        n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", done); end
        n_vec++; if (PC_Enable !== 1'b1) begin n_bad++; $display("FAIL basic_pc: got %b want 1", PC_Enable); end
        n_vec++; if (error !== 1'b0) begin n_bad++; $display("FAIL basic_error: got %b want 0", error); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        // RUN ignores further bytes
        send(8'hA5); send(8'h00);
        idle(1);
        n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_run_hold: got done=%b busy=%b want done=1 busy=0", done, busy); end
        n_vec++; if (wr_count - w0 !== 2) begin n_bad++; $display("FAIL basic_wr_count: got %0d want 2", wr_count - w0); end
        n_vec++; if (mem[0] !== 11'h590 || mem[1] !== 11'h65C) begin n_bad++; $display("FAIL basic_mem: got %h %h want 590 65C", mem[0], mem[1]); end
    endtask

    task automatic test_wrap();
        do_reset();
        send(8'hA5); send(8'h07); send(8'h02); send(8'h00); send(8'h03);
        n_vec++; if (RAM_Write_Address !== 3'd7 || RAM_Write_Data !== 11'h003) begin n_bad++; $display("FAIL wrap_w0: got a=%0d d=%h want a=7 d=003", RAM_Write_Address, RAM_Write_Data); end
        send(8'h05); send(8'h90);
        n_vec++; if (RAM_Write_Address !== 3'd0 || RAM_Write_Data !== 11'h590) begin n_bad++; $display("FAIL wrap_w1: got a=%0d d=%h want a=0 d=590", RAM_Write_Address, RAM_Write_Data); end
        send(8'hA1);
        n_vec++; if (PC_Enable !== 1'b1) begin n_bad++; $display("FAIL wrap_pc: got %b want 1", PC_Enable); end
        idle(1);
        n_vec++; if (mem[7] !== 11'h003 || mem[0] !== 11'h590) begin n_bad++; $display("FAIL wrap_mem: got %h %h want 003 590", mem[7], mem[0]); end
    endtask

    task automatic test_bad_csum();
        int w0;
        do_reset();
        w0 = wr_count;
        send(8'hA5); send(8'h00); send(8'h02); send(8'h05);
        send(8'h90); send(8'h06); send(8'h5C); send(8'h00);
        n_vec++; if (error !== 1'b1) begin n_bad++; $display("FAIL csum_error: got %b want 1", error); end
        n_vec++; if (PC_Enable !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL csum_pc: got pc=%b done=%b want 0 0", PC_Enable, done); end
        idle(1);
        n_vec++; if (wr_count - w0 !== 2) begin n_bad++; $display("FAIL csum_writes: got %0d want 2", wr_count - w0); end
        n_vec++; if (mem[1] !== 11'h65C) begin n_bad++; $display("FAIL csum_mem: got %h want 65C", mem[1]); end
        send(8'hA5);
        n_vec++; if (error !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL csum_resync: got err=%b busy=%b want 0 1", error, busy); end
        send(8'h00); send(8'h02); send(8'h05); send(8'h90);
        send(8'h06); send(8'h5C); send(8'hF9);
        n_vec++; if (done !== 1'b1 || error !== 1'b0 || PC_Enable !== 1'b1) begin n_bad++; $display("FAIL csum_recover: got done=%b err=%b pc=%b want 1 0 1", done, error, PC_Enable); end
    endtask

    task automatic test_illegal();
        logic [7:0] fr [4][4];
        int len [4];
        int w0;
        fr[0] = '{8'hA5, 8'h00, 8'h00, 8'h00}; len[0] = 3;
        fr[1] = '{8'hA5, 8'h00, 8'h09, 8'h00}; len[1] = 3;
        fr[2] = '{8'hA5, 8'h00, 8'h01, 8'h08}; len[2] = 4;
        fr[3] = '{8'hA5, 8'h08, 8'h00, 8'h00}; len[3] = 2;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            w0 = wr_count;
            for (int j = 0; j < len[k]; j++) send(fr[k][j]);
            n_vec++; if (error !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL illegal_%0d: got err=%b busy=%b want 1 0", k, error, busy); end
            idle(2);
            n_vec++; if (wr_count !== w0) begin n_bad++; $display("FAIL illegal_wr_%0d: got %0d writes want 0", k, wr_count - w0); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send(8'hA5); send(8'h00); send(8'h02);
        idle(15);
        n_vec++; if (error !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL tmo_early: got err=%b busy=%b want 0 1", error, busy); end
        idle(1);
        n_vec++; if (error !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL tmo_fire: got err=%b busy=%b want 1 0", error, busy); end
        do_reset();
        send(8'hA5); send(8'h00); send(8'h02);
        idle(15);
        send(8'h05);
        n_vec++; if (error !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL tmo_rescue: got err=%b busy=%b want 0 1", error, busy); end
    endtask

    task automatic test_reset_mid();
        int w0;
        do_reset();
        send(8'hA5); send(8'h00); send(8'h02); send(8'h05); send(8'h90); send(8'h06);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_vec++; if (RAM_Write_Data !== 11'h000 || RAM_Write_Address !== 3'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_regs: got d=%h a=%0d busy=%b want 000 0 0", RAM_Write_Data, RAM_Write_Address, busy); end
        send(8'hA5); send(8'h00); send(8'h02); send(8'h05);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_vec++; if (busy !== 1'b0 || RAM_Write_Enable !== 1'b0 || error !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out: got busy=%b we=%b err=%b done=%b want 0", busy, RAM_Write_Enable, error, done); end
        w0 = wr_count;
        send(8'h90); send(8'h06);
        idle(2);
        n_vec++; if (wr_count !== w0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_ignored: got writes=%0d busy=%b want 0 0", wr_count - w0, busy); end
        send(8'hA5); send(8'h00); send(8'h02); send(8'h05);
        send(8'h90); send(8'h06); send(8'h5C); send(8'hF9);
        idle(1);
        n_vec++; if (done !== 1'b1 || wr_count - w0 !== 2 || mem[1] !== 11'h65C) begin n_bad++; $display("FAIL mid_reload: got done=%b writes=%0d m1=%h want 1 2 65C", done, wr_count - w0, mem[1]); end
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_basic();
        test_wrap();
        test_bad_csum();
        test_illegal();
        test_timeout();
        test_reset_mid();
        n_vec++; if (dbl_count !== 0) begin n_bad++; $display("FAIL we_pulse_width: got %0d multi-cycle pulses want 0", dbl_count); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
